// File: rtl/char_health_ctrl.sv
// Player health and life-cycle controller: damage/heal, invulnerability frames,
// death timer, one-cycle respawn pulse and draw-flicker flag. All outputs registered.
module char_health_ctrl #(
  parameter int unsigned MAX_HP        = 8,
  parameter int unsigned IFRAME_FRAMES = 60,
  parameter int unsigned DEATH_FRAMES  = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       game_start,
  input  logic       hit,
  input  logic [3:0] hit_dmg,
  input  logic       heal,
  input  logic [3:0] heal_amt,
  output logic [3:0] current_health,
  output logic       invuln,
  output logic       blink,
  output logic       char_dead,
  output logic       freeze,
  output logic       respawn
);

  localparam logic [3:0] MaxHp      = 4'(MAX_HP);
  localparam logic [7:0] IframeLast = 8'(IFRAME_FRAMES);
  localparam logic [7:0] DeathLast  = 8'(DEATH_FRAMES);

  typedef enum logic [2:0] {
    StIdle,
    StAlive,
    StHurt,
    StDead,
    StRespawn
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] health_q, health_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       invuln_d, blink_d, char_dead_d, freeze_d, respawn_d;

  logic [7:0] fcnt_inc;
  logic [4:0] heal_sum;
  logic [3:0] healed_hp;
  logic [3:0] damaged_hp;

  always_comb begin
    fcnt_inc   = fcnt_q + 8'd1;
    heal_sum   = {1'b0, health_q} + {1'b0, heal_amt};
    healed_hp  = (heal_sum > {1'b0, MaxHp}) ? MaxHp : heal_sum[3:0];
    // Saturate at zero instead of wrapping the 4-bit value.
    damaged_hp = (hit_dmg >= health_q) ? 4'd0 : health_q - hit_dmg;
  end

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    fcnt_d   = fcnt_q;

    unique case (state_q)
      StIdle: begin
        if (game_start) begin
          state_d  = StRespawn;
          health_d = MaxHp;
          fcnt_d   = 8'd0;
        end
      end
      StAlive: begin
        // A real hit wins over a same-cycle heal; a zero-damage hit is a no-op.
        if (hit && (hit_dmg != 4'd0)) begin
          health_d = damaged_hp;
          fcnt_d   = 8'd0;
          state_d  = (damaged_hp == 4'd0) ? StDead : StHurt;
        end else if (heal) begin
          health_d = healed_hp;
        end
      end
      StHurt: begin
        if (heal) begin
          health_d = healed_hp;
        end
        if (frame_tick) begin
          if (fcnt_inc == IframeLast) begin
            state_d = StAlive;
            fcnt_d  = 8'd0;
          end else begin
            fcnt_d = fcnt_inc;
          end
        end
      end
      StDead: begin
        health_d = 4'd0;
        if (frame_tick) begin
          if (fcnt_inc == DeathLast) begin
            state_d  = StRespawn;
            health_d = MaxHp;
            fcnt_d   = 8'd0;
          end else begin
            fcnt_d = fcnt_inc;
          end
        end
      end
      StRespawn: begin
        state_d = StHurt;
        fcnt_d  = 8'd0;
      end
      default: begin
        state_d  = StIdle;
        health_d = MaxHp;
        fcnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    invuln_d    = (state_d == StHurt);
    blink_d     = (state_d == StHurt) ? ~fcnt_d[2] : 1'b1;
    char_dead_d = (state_d == StDead);
    freeze_d    = (state_d == StIdle) || (state_d == StDead) || (state_d == StRespawn);
    respawn_d   = (state_d == StRespawn);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      health_q  <= MaxHp;
      fcnt_q    <= 8'd0;
      invuln    <= 1'b0;
      blink     <= 1'b0;
      char_dead <= 1'b0;
      freeze    <= 1'b1;
      respawn   <= 1'b0;
    end else begin
      state_q   <= state_d;
      health_q  <= health_d;
      fcnt_q    <= fcnt_d;
      invuln    <= invuln_d;
      blink     <= blink_d;
      char_dead <= char_dead_d;
      freeze    <= freeze_d;
      respawn   <= respawn_d;
    end
  end

  assign current_health = health_q;

endmodule

// File: tb/tb_char_health_ctrl.sv
// Directed plus randomized bench for char_health_ctrl against a behavioural model
// of the character's life cycle.
module tb_char_health_ctrl;

  localparam int MaxHp  = 8;
  localparam int Iframe = 60;
  localparam int Death  = 120;

  localparam int MIdle = 0, MAlive = 1, MHurt = 2, MDead = 3, MResp = 4;

  logic       clk = 1'b0;
  logic       rst, frame_tick, game_start, hit, heal;
  logic [3:0] hit_dmg, heal_amt;
  logic [3:0] current_health;
  logic       invuln, blink, char_dead, freeze, respawn;

  int vectors = 0;
  int miscompares = 0;

  int m_mode, m_hp, m_ticks;
  bit m_fresh_reset;

  always #5 clk = ~clk;

  char_health_ctrl #(
    .MAX_HP       (MaxHp),
    .IFRAME_FRAMES(Iframe),
    .DEATH_FRAMES (Death)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .game_start    (game_start),
    .hit           (hit),
    .hit_dmg       (hit_dmg),
    .heal          (heal),
    .heal_amt      (heal_amt),
    .current_health(current_health),
    .invuln        (invuln),
    .blink         (blink),
    .char_dead     (char_dead),
    .freeze        (freeze),
    .respawn       (respawn)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Life-cycle rules applied to one clock edge's inputs.
  task automatic model_step(input bit r, input bit gs, input bit tk, input bit h,
                            input int dmg, input bit hl, input int amt);
    if (r) begin
      m_mode = MIdle; m_hp = MaxHp; m_ticks = 0; m_fresh_reset = 1;
      return;
    end
    m_fresh_reset = 0;
    case (m_mode)
      MIdle: if (gs) begin m_mode = MResp; m_hp = MaxHp; end
      MAlive: begin
        if (h && dmg != 0) begin
          m_hp    = (dmg >= m_hp) ? 0 : m_hp - dmg;
          m_ticks = 0;
          m_mode  = (m_hp == 0) ? MDead : MHurt;
        end else if (hl) begin
          m_hp = (m_hp + amt > MaxHp) ? MaxHp : m_hp + amt;
        end
      end
      MHurt: begin
        if (hl) m_hp = (m_hp + amt > MaxHp) ? MaxHp : m_hp + amt;
        if (tk) begin
          m_ticks++;
          if (m_ticks == Iframe) begin m_mode = MAlive; m_ticks = 0; end
        end
      end
      MDead: begin
        if (tk) begin
          m_ticks++;
          if (m_ticks == Death) begin m_mode = MResp; m_hp = MaxHp; m_ticks = 0; end
        end
      end
      default: begin m_mode = MHurt; m_ticks = 0; end
    endcase
  endtask

  task automatic check_all();
    bit exp_blink;
    if (m_fresh_reset) exp_blink = 0;
    else if (m_mode == MHurt) exp_blink = ((m_ticks / 4) % 2) == 0;
    else exp_blink = 1;
    chk("health", 8'(current_health), 8'(m_hp));
    chk("invuln", 8'(invuln), 8'(m_mode == MHurt));
    chk("blink", 8'(blink), 8'(exp_blink));
    chk("char_dead", 8'(char_dead), 8'(m_mode == MDead));
    chk("freeze", 8'(freeze), 8'(m_mode == MIdle || m_mode == MDead || m_mode == MResp));
    chk("respawn", 8'(respawn), 8'(m_mode == MResp));
  endtask

  task automatic cyc(input bit r, input bit gs, input bit tk, input bit h, input int dmg,
                     input bit hl, input int amt);
    rst = r; game_start = gs; frame_tick = tk; hit = h; hit_dmg = 4'(dmg);
    heal = hl; heal_amt = 4'(amt);
    @(posedge clk);
    model_step(r, gs, tk, h, dmg, hl, amt);
    #1;
    check_all();
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] blink_pat;
    bit r, gs, tk, h, hl;
    int dmg, amt;
    blink_pat = 8'b0000_1111;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_blink_low", 8'(blink), 8'd0);
    chk("rst_freeze", 8'(freeze), 8'd1);
    cyc(0, 0, 1, 1, 5, 1, 3);  // IDLE ignores hit/heal/tick
    chk("idle_hit_ignored", 8'(current_health), 8'd8);

    // game_start -> one-cycle respawn -> HURT for 60 ticks
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("respawn_pulse", 8'(respawn), 8'd1);
    chk("respawn_hp", 8'(current_health), 8'd8);
    idle_cyc();
    chk("spawn_invuln", 8'(invuln), 8'd1);
    chk("respawn_drop", 8'(respawn), 8'd0);
    ticks(59);
    chk("iframe_59", 8'(invuln), 8'd1);
    ticks(1);
    chk("iframe_done", 8'(invuln), 8'd0);

    // Back-to-back hits and blink pattern
    cyc(0, 0, 0, 1, 3, 0, 0);
    cyc(0, 0, 0, 1, 3, 0, 0);
    chk("second_hit_ignored", 8'(current_health), 8'd5);
    chk("blink_0", 8'(blink), 8'(blink_pat[0]));
    for (int k = 1; k < 8; k++) begin
      ticks(1);
      chk("blink_pat", 8'(blink), 8'(blink_pat[k]));
    end
    ticks(Iframe - 7);
    chk("hurt_over", 8'(invuln), 8'd0);

    // Lethal hit saturates at zero, then death timer and respawn
    cyc(0, 0, 0, 1, 3, 0, 0);
    ticks(Iframe);
    cyc(0, 0, 0, 1, 7, 0, 0);
    chk("no_wrap", 8'(current_health), 8'd0);
    chk("dead_flag", 8'(char_dead), 8'd1);
    cyc(0, 1, 0, 1, 1, 1, 4);  // ignored while dead
    ticks(Death - 1);
    chk("still_dead", 8'(char_dead), 8'd1);
    ticks(1);
    chk("death_respawn", 8'(respawn), 8'd1);
    chk("death_respawn_hp", 8'(current_health), 8'd8);
    ticks(Iframe + 1);

    // Heal saturation and hit-over-heal priority
    cyc(0, 0, 0, 1, 2, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 15);
    chk("heal_sat", 8'(current_health), 8'd8);
    ticks(Iframe);
    cyc(0, 0, 0, 1, 2, 1, 4);
    chk("hit_beats_heal", 8'(current_health), 8'd6);
    ticks(Iframe);

    // Zero-damage hit and game_start in ALIVE
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("dmg0_noop", 8'(invuln), 8'd0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("gs_alive_ignored", 8'(respawn), 8'd0);

    // Reset mid-DEAD
    cyc(0, 0, 0, 1, 15, 0, 0);
    ticks(50);
    cyc(1, 0, 1, 1, 3, 0, 0);
    chk("rst_dead_hp", 8'(current_health), 8'd8);
    chk("rst_dead_flag", 8'(char_dead), 8'd0);
    chk("rst_dead_freeze", 8'(freeze), 8'd1);
    cyc(0, 0, 0, 1, 3, 0, 0);
    chk("post_rst_hit", 8'(current_health), 8'd8);

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      r   = ($urandom_range(0, 599) == 0);
      gs  = ($urandom_range(0, 39) == 0);
      tk  = ($urandom_range(0, 1) == 0);
      h   = ($urandom_range(0, 7) == 0);
      dmg = $urandom_range(0, 15);
      hl  = ($urandom_range(0, 5) == 0);
      amt = $urandom_range(0, 15);
      if (h && dmg == 0) hl = 0;
      cyc(r, gs, tk, h, dmg, hl, amt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/char_health_ctrl.md
# char_health_ctrl

Health and life-cycle controller for the player character. It accepts damage and heal events from the collision and pickup logic and owns the `current_health` value consumed by the character block. It sequences invulnerability frames, death, a timed respawn and the draw-flicker flag. It sits between the collision/game-state logic and the character move/draw datapath, which it gates through `freeze` and `respawn`.

## Interface
Parameters:
- MAX_HP, 8, full health; legal range 1..15.
- IFRAME_FRAMES, 60, frames of invulnerability after a non-lethal hit or a respawn; legal range 1..255.
- DEATH_FRAMES, 120, frames spent in DEAD before respawn; legal range 1..255.

Ports:
- clk  in  1  system clock (pixel clock domain); single clock.
- rst  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse once per frame (end of active video).
- game_start  in  1  one-cycle pulse from the menu/game-state logic.
- hit  in  1  one-cycle damage request.
- hit_dmg  in  4  damage amount, sampled with `hit`.
- heal  in  1  one-cycle heal request.
- heal_amt  in  4  heal amount, sampled with `heal`.
- current_health  out  4  registered health value, 0..MAX_HP.
- invuln  out  1  high in HURT.
- blink  out  1  draw-flicker flag; low means the sprite is hidden this frame.
- char_dead  out  1  high in DEAD.
- freeze  out  1  movement disable; high in IDLE, DEAD and RESPAWN.
- respawn  out  1  one-cycle pulse; the character position controller reloads its start position on it.

## Operation
- States: IDLE, ALIVE, HURT, DEAD, RESPAWN. One 8-bit frame counter `fcnt`.
- Reset state is IDLE with `current_health`=MAX_HP, `fcnt`=0, `freeze`=1, and `invuln`, `blink`, `char_dead` and `respawn` all 0.
- IDLE:
  - `game_start` moves to RESPAWN.
  - `hit`, `heal` and `frame_tick` are ignored.
- ALIVE, on `hit` with `hit_dmg`≠0:
  - New health = max(health − hit_dmg, 0), saturating. No 4-bit wrap.
  - If the result is 0, go to DEAD. Otherwise go to HURT.
  - `fcnt` is cleared to 0 on either transition.
- ALIVE, on `hit` with `hit_dmg`=0: no effect.
- HURT:
  - `hit` is ignored.
  - Each `frame_tick` increments `fcnt`.
  - On the tick that makes `fcnt`=IFRAME_FRAMES, go to ALIVE.
- `heal` is accepted only in ALIVE and HURT. New health = min(health + heal_amt, MAX_HP), computed in 5 bits and then saturated.
- Simultaneous `hit` and `heal` in ALIVE: the hit is applied and the heal is dropped. Heal is never merged with damage.
- In HURT, simultaneous `heal` and `frame_tick` both take effect.
- DEAD:
  - `current_health` stays 0.
  - `hit`, `heal` and `game_start` are ignored.
  - `frame_tick` increments `fcnt`. On the tick that makes `fcnt`=DEATH_FRAMES, go to RESPAWN.
- RESPAWN lasts exactly one cycle:
  - `respawn`=1 and `current_health` is loaded with MAX_HP in the same cycle.
  - Next state is HURT with `fcnt`=0, which gives spawn protection.
- `blink` = ~`fcnt`[2] in HURT and 1 in every other state. Result: the sprite is visible for 4 frames, then hidden for 4 frames, starting visible.
- `game_start` outside IDLE is ignored.
- A `frame_tick` in the cycle of a state transition is not counted by the new state.

## Timing
- All outputs are registered.
- An input pulse at edge N is reflected in `current_health`, `invuln` and `char_dead` after edge N, i.e. visible in cycle N+1.
- `respawn` is high for exactly one cycle. `current_health`=MAX_HP is visible in that same cycle.
- Latency from `game_start` to `respawn` is 1 cycle. `invuln` rises the cycle after `respawn`.
- Death duration is exactly DEATH_FRAMES `frame_tick` pulses, counted from the first tick after entry.
- Invulnerability duration is exactly IFRAME_FRAMES ticks, counted the same way.
- Synchronous `rst` asserted in any state, including mid-HURT or mid-DEAD, returns to the reset state on the next edge. It has priority over all inputs.
- Back-to-back `hit` pulses: only the first is applied. The second arrives in HURT or DEAD and is ignored.

## Test plan
- Reset then `game_start`: `respawn` pulses one cycle with health=8, then HURT. After 60 ticks, `invuln`=0 and state is ALIVE.
- ALIVE, health 8, `hit` with dmg 3, then a second `hit` with dmg 3 on the next cycle: health=5, `invuln`=1, second hit ignored. `blink` pattern over 8 ticks is 1,1,1,1,0,0,0,0.
- ALIVE, health 2, `hit` with dmg 7: health=0 (no wrap to 11), `char_dead`=1, `freeze`=1. After 120 ticks, `respawn` pulse with health=8.
- Health 6, `heal` with amt 15: health=8 (saturated). Same-cycle `hit` dmg 2 with `heal` 4 at health 8: health=6.
- `rst` asserted mid-DEAD at `fcnt`=50: next cycle is IDLE with health=8, `char_dead`=0 and `freeze`=1. Subsequent `hit` is ignored.
- `hit` with dmg 0 in ALIVE: no state change. `game_start` in ALIVE: ignored, no `respawn` pulse.
